// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with per-step enables and mux selects.
// 3-5 cycles per instruction; FETCH and MEM hold their request until memReady; TRAP is sticky until rst.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        brEq,
    input  logic        brLt,
    input  logic        memReady,
    output logic        pcWrite,
    output logic        oldPcWrite,
    output logic        irWrite,
    output logic        regWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        iorD,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [2:0]  aluOp,
    output logic [1:0]  memtoReg,
    output logic        pcSource,
    output logic [2:0]  state,
    output logic        retire,
    output logic [31:0] instret,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_RFN   = 3'b010;
    localparam logic [2:0] ALU_IFN   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    state_t cur, nxt;

    logic is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic opc_legal, br_bad, br_taken;

    // Unqualified enables; rst masks them below so a reset cycle never writes state.
    logic pc_wr_c, old_pc_wr_c, ir_wr_c, reg_wr_c, mem_rd_c, mem_wr_c, retire_c;

    always_comb begin
        is_r     = (opcode == OP_R);
        is_i     = (opcode == OP_I);
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_br    = (opcode == OP_BR);
        is_jal   = (opcode == OP_JAL);
        is_jalr  = (opcode == OP_JALR);
        is_lui   = (opcode == OP_LUI);
        is_auipc = (opcode == OP_AUIPC);
        opc_legal = is_r | is_i | is_load | is_store | is_br |
                    is_jal | is_jalr | is_lui | is_auipc;
        br_bad    = is_br && (funct3 == 3'b010 || funct3 == 3'b011);
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:          br_taken = brEq;
            3'b001:          br_taken = ~brEq;
            3'b100, 3'b110:  br_taken = brLt;
            3'b101, 3'b111:  br_taken = ~brLt;
            default:         br_taken = 1'b0;
        endcase
    end

    always_comb begin
        nxt         = cur;
        pc_wr_c     = 1'b0;
        old_pc_wr_c = 1'b0;
        ir_wr_c     = 1'b0;
        reg_wr_c    = 1'b0;
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        retire_c    = 1'b0;
        iorD        = 1'b0;
        aluSrcA     = SRCA_PC;
        aluSrcB     = SRCB_RS2;
        aluOp       = ALU_ADD;
        memtoReg    = WB_ALUOUT;
        pcSource    = 1'b0;

        case (cur)
            S_FETCH: begin
                if (run) begin
                    mem_rd_c = 1'b1;
                    aluSrcB  = SRCB_FOUR;
                    if (memReady) begin
                        ir_wr_c     = 1'b1;
                        pc_wr_c     = 1'b1;
                        old_pc_wr_c = 1'b1;
                        nxt         = S_DECODE;
                    end
                end
            end

            // ALUOut captures oldPC+imm here as the branch/JAL target.
            S_DECODE: begin
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                if (!opc_legal || br_bad) nxt = S_TRAP;
                else                      nxt = S_EXEC;
            end

            S_EXEC: begin
                if (is_r) begin
                    aluSrcA = SRCA_RS1;
                    aluSrcB = SRCB_RS2;
                    aluOp   = ALU_RFN;
                    nxt     = S_WB;
                end else if (is_i) begin
                    aluSrcA = SRCA_RS1;
                    aluSrcB = SRCB_IMM;
                    aluOp   = ALU_IFN;
                    nxt     = S_WB;
                end else if (is_load || is_store) begin
                    aluSrcA = SRCA_RS1;
                    aluSrcB = SRCB_IMM;
                    nxt     = S_MEM;
                end else if (is_lui) begin
                    aluSrcB = SRCB_IMM;
                    aluOp   = ALU_PASSB;
                    nxt     = S_WB;
                end else if (is_auipc) begin
                    aluSrcA = SRCA_OLDPC;
                    aluSrcB = SRCB_IMM;
                    nxt     = S_WB;
                end else if (is_br) begin
                    pc_wr_c  = br_taken;
                    pcSource = 1'b1;
                    retire_c = 1'b1;
                    nxt      = S_FETCH;
                end else if (is_jal) begin
                    reg_wr_c = 1'b1;
                    memtoReg = WB_PC;
                    pc_wr_c  = 1'b1;
                    pcSource = 1'b1;
                    retire_c = 1'b1;
                    nxt      = S_FETCH;
                end else if (is_jalr) begin
                    // rd gets the pre-edge PC (oldPC+4) while PC takes rs1+imm live.
                    aluSrcA  = SRCA_RS1;
                    aluSrcB  = SRCB_IMM;
                    pc_wr_c  = 1'b1;
                    reg_wr_c = 1'b1;
                    memtoReg = WB_PC;
                    retire_c = 1'b1;
                    nxt      = S_FETCH;
                end else begin
                    nxt = S_TRAP;
                end
            end

            S_MEM: begin
                iorD     = 1'b1;
                mem_rd_c = is_load;
                mem_wr_c = is_store;
                if (!(is_load || is_store)) begin
                    nxt = S_TRAP;
                end else if (memReady) begin
                    if (is_load) begin
                        nxt = S_WB;
                    end else begin
                        retire_c = 1'b1;
                        nxt      = S_FETCH;
                    end
                end
            end

            S_WB: begin
                reg_wr_c = 1'b1;
                memtoReg = is_load ? WB_MDR : WB_ALUOUT;
                retire_c = 1'b1;
                nxt      = S_FETCH;
            end

            S_TRAP: nxt = S_TRAP;

            default: nxt = S_FETCH;
        endcase
    end

    assign pcWrite    = pc_wr_c     & ~rst;
    assign oldPcWrite = old_pc_wr_c & ~rst;
    assign irWrite    = ir_wr_c     & ~rst;
    assign regWrite   = reg_wr_c    & ~rst;
    assign memRead    = mem_rd_c    & ~rst;
    assign memWrite   = mem_wr_c    & ~rst;
    assign retire     = retire_c    & ~rst;
    assign state      = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_FETCH;
            instret <= 32'd0;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (retire)          instret <= instret + 32'd1;
            if (nxt == S_TRAP)   illegal <= 1'b1;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I datapath. It replaces the single-cycle combinational control: it splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps and drives per-step enables and mux selects for the PC, instruction register, register file, ALU, and one unified memory. Memory accesses use a ready handshake so wait states are supported. It also keeps a retired-instruction counter and flags illegal instructions.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  permits a new fetch; sampled only in FETCH.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- brEq, brLt  in  1 each  comparator outputs for rs1/rs2 (signed lt).
- memReady  in  1  memory completes the current request this cycle.
- pcWrite, oldPcWrite, irWrite, regWrite  out  1 each  register enables.
- memRead, memWrite  out  1 each  memory request.
- iorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- aluSrcA  out  2  ALU A select: 0 = PC, 1 = oldPC, 2 = rs1 reg.
- aluSrcB  out  2  ALU B select: 0 = rs2 reg, 1 = imm, 2 = const 4.
- aluOp  out  3  ALU op: 000 = ADD, 010 = R-type funct, 011 = I-type funct, 100 = pass B.
- memtoReg  out  2  writeback select: 0 = ALUOut, 1 = MDR, 2 = PC.
- pcSource  out  1  PC next select: 0 = live ALU result, 1 = ALUOut reg.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- retire  out  1  one-cycle pulse on an instruction's final cycle.
- instret  out  32  retired-instruction count; wraps modulo 2^32.
- illegal  out  1  sticky; set on entry to TRAP.

## Operation
- Outputs are combinational from state, opcode, funct3, brEq, brLt, and memReady. Any output not listed for a step is 0.
- **FETCH**
  - If run=0: idle; no outputs asserted.
  - If run=1: memRead=1, iorD=0, aluSrcA=0, aluSrcB=2, aluOp=ADD, pcSource=0.
  - On the cycle memReady=1: irWrite, pcWrite, and oldPcWrite=1; next state DECODE. Otherwise stay in FETCH.
- **DECODE**
  - aluSrcA=1, aluSrcB=1, ADD, so ALUOut = oldPC+imm.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} -> TRAP.
  - BRANCH with funct3 ∈ {010, 011} -> TRAP.
  - Otherwise -> EXEC.
- **EXEC**, per opcode:
  - R: A=2, B=0, aluOp=010 -> WB.
  - I-ALU: A=2, B=1, aluOp=011 -> WB.
  - LOAD/STORE: A=2, B=1, ADD -> MEM.
  - LUI: B=1, aluOp=100 -> WB.
  - AUIPC: A=1, B=1, ADD -> WB.
  - BRANCH: taken = (000: brEq), (001: !brEq), (100, 110: brLt), (101, 111: !brLt). If taken: pcWrite=1, pcSource=1. Retire -> FETCH.
  - JAL: regWrite=1, memtoReg=2, pcWrite=1, pcSource=1. Retire -> FETCH.
  - JALR: A=2, B=1, ADD, pcSource=0, pcWrite=1, regWrite=1, memtoReg=2. Retire -> FETCH. The link value is the pre-edge PC (= oldPC+4).
- **MEM**
  - iorD=1. LOAD: memRead=1. STORE: memWrite=1.
  - Held until memReady=1.
  - On completion: LOAD -> WB; STORE retires -> FETCH.
- **WB**
  - regWrite=1. memtoReg=1 for LOAD, 0 otherwise.
  - Retire -> FETCH.
- **TRAP**: all enables 0, illegal=1. Stays in TRAP until rst.
- **instret**: increments by 1 on each retire edge.

## Timing
- Reset values: state=FETCH, instret=0, illegal=0.
- During any cycle with rst=1:
  - All write/request outputs are forced 0, i.e. pcWrite, oldPcWrite, irWrite, regWrite, memRead, memWrite, and retire.
  - The next state is FETCH, from any state, including mid-MEM or TRAP.
- Cycle counts with memReady=1 throughout:
  - BRANCH, JAL, JALR: 3 cycles.
  - R, I-ALU, LUI, AUIPC, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each memReady=0 cycle during FETCH or MEM adds exactly one cycle.
- memReady is ignored when memRead and memWrite are both 0.
- Request signals stay stable until acceptance. The address select does not change while waiting.
- run is checked only at an instruction boundary. Deasserting run mid-instruction completes the instruction.
- retire and the instret increment occur in the same cycle as the final state's enables. The next FETCH begins on the following cycle.

## Test plan
- **R-type add**, run=1, memReady=1: state sequence 0,1,2,4,0. regWrite=1 only in WB with memtoReg=0. instret 0->1 at the WB edge.
- **LOAD with memReady=0 for 2 MEM cycles**: memRead=1 and iorD=1 held for 3 cycles. Total 7 cycles. WB memtoReg=1. retire pulses once.
- **BEQ**:
  - brEq=1: pcWrite=1, pcSource=1 in EXEC, back in FETCH after 3 cycles.
  - brEq=0: pcWrite=0 in EXEC. Both cases retire.
- **JAL**: EXEC asserts regWrite, pcWrite, memtoReg=2, pcSource=1 in the same cycle. No WB state.
- **Illegal instructions**:
  - opcode 1111111: DECODE -> TRAP; illegal=1; all enables 0 for 10 cycles.
  - BRANCH with funct3=010: also -> TRAP.
  - rst then restores FETCH with illegal=0.
- **run and reset**:
  - run=0 in FETCH: no memRead for 5 cycles.
  - rst asserted mid-MEM of a STORE: memWrite=0 during rst, state=FETCH next cycle, instret=0.
